i2c_target: RTL and testbench

// - I2C target (responder) that sits opposite i2c_controller on the shared SCL/SDA bus.
// - Oversamples SCL/SDA on the system clock and detects START, repeated START and STOP.
// - Matches a 7-bit address, then receives write bytes or returns read bytes.
// - Presents bytes to local logic through a simple pulse/hold interface.

---
 rtl/i2c_pkg.sv | 24 ++
 rtl/i2c_line_sync.sv | 36 +++
 rtl/i2c_target.sv | 219 +++++++++++++++++++++
 tb/tb_i2c_target.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// Shared I2C definitions: target FSM states, bus-level constants and widths.
// Used by i2c_target and i2c_controller.
package i2c_pkg;

    localparam int unsigned I2C_BYTE_W    = 8;
    localparam int unsigned I2C_ADDR_W    = 7;
    localparam int unsigned I2C_BIT_CNT_W = 3;

    localparam logic I2C_ACK     = 1'b0;
    localparam logic I2C_NACK    = 1'b1;
    localparam logic I2C_RW_READ = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        RX,
        RX_ACK,
        TX,
        TX_ACK,
        IGNORE
    } i2c_target_state_e;

endpackage

// File: rtl/i2c_line_sync.sv
// Synchronizer for one bus line, with registered edge detect.
// Ports:
//   clk, rst   system clock, async active-low reset (chain resets to idle-high)
//   pin        raw line level
//   level      synchronized level
//   rise/fall  one-cycle pulses, asserted in the same cycle level changes
module i2c_line_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic pin,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] chain_q;

    // Edges come from the value about to enter the last stage, so the
    // pulses line up with the level they describe.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            chain_q <= '1;
            rise    <= 1'b0;
            fall    <= 1'b0;
        end else begin
            chain_q <= {chain_q[SYNC_STAGES-2:0], pin};
            rise    <= chain_q[SYNC_STAGES-2] & ~chain_q[SYNC_STAGES-1];
            fall    <= ~chain_q[SYNC_STAGES-2] & chain_q[SYNC_STAGES-1];
        end
    end

    assign level = chain_q[SYNC_STAGES-1];

endmodule

// File: rtl/i2c_target.sv
// I2C target: detects START/STOP on oversampled SCL/SDA, matches a 7-bit
// address, receives write bytes and returns read bytes.
// Ports:
//   clk, rst          system clock (>= 8x SCL), async active-low reset
//   scl_i, sda_i      bus line levels
//   sda_oe            1 = pull SDA low
//   rx_data/rx_valid  received byte and its one-cycle strobe
//   rx_full           sink full: NACK the incoming data byte
//   tx_data/tx_req    read byte, sampled in the cycle tx_req is high
//   busy              addressed and transfer in progress
module i2c_target
    import i2c_pkg::*;
#(
    parameter logic [6:0]  TARGET_ADDR = 7'h54,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       sda_oe,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_full,
    input  logic [7:0] tx_data,
    output logic       tx_req,
    output logic       busy
);

    logic scl_lvl, scl_rise, scl_fall;
    logic sda_lvl, sda_rise, sda_fall;
    logic start_evt, stop_evt;

    i2c_target_state_e state_q, state_d;
    logic [I2C_BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [I2C_BYTE_W-1:0]    shift_q, shift_d, shifted;
    logic                     got8_q, got8_d;
    logic                     nack_q, nack_d;
    logic                     sda_oe_d, rx_valid_d, tx_req_d, busy_d;
    logic [I2C_BYTE_W-1:0]    rx_data_d;

    i2c_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_scl_sync (
        .clk   (clk),
        .rst   (rst),
        .pin   (scl_i),
        .level (scl_lvl),
        .rise  (scl_rise),
        .fall  (scl_fall)
    );

    i2c_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sda_sync (
        .clk   (clk),
        .rst   (rst),
        .pin   (sda_i),
        .level (sda_lvl),
        .rise  (sda_rise),
        .fall  (sda_fall)
    );

    // SDA only moves while SCL is high at START/STOP; data changes while SCL is low.
    assign start_evt = sda_fall & scl_lvl;
    assign stop_evt  = sda_rise & scl_lvl;
    assign shifted   = {shift_q[I2C_BYTE_W-2:0], sda_lvl};

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            got8_q    <= 1'b0;
            nack_q    <= 1'b0;
            sda_oe    <= 1'b0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            tx_req    <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            got8_q    <= got8_d;
            nack_q    <= nack_d;
            sda_oe    <= sda_oe_d;
            rx_data   <= rx_data_d;
            rx_valid  <= rx_valid_d;
            tx_req    <= tx_req_d;
            busy      <= busy_d;
        end
    end

    // Next-state and output logic.
    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        got8_d     = got8_q;
        nack_d     = nack_q;
        sda_oe_d   = sda_oe;
        rx_data_d  = rx_data;
        rx_valid_d = 1'b0;
        tx_req_d   = 1'b0;
        busy_d     = busy;

        if (start_evt) begin
            state_d   = ADDR;
            bit_cnt_d = '0;
            got8_d    = 1'b0;
            sda_oe_d  = 1'b0;
            busy_d    = 1'b0;
        end else if (stop_evt) begin
            state_d  = IDLE;
            got8_d   = 1'b0;
            sda_oe_d = 1'b0;
            busy_d   = 1'b0;
        end else begin
            // tx_req was raised on the previous scl_fall; the byte is captured
            // now and its MSB goes straight onto the bus.
            if (tx_req && state_q == TX) begin
                shift_d  = tx_data;
                sda_oe_d = ~tx_data[I2C_BYTE_W-1];
            end

            case (state_q)
                IDLE: ;

                ADDR: begin
                    if (scl_rise) begin
                        shift_d   = shifted;
                        bit_cnt_d = I2C_BIT_CNT_W'(bit_cnt_q + 1'b1);
                        if (bit_cnt_q == '1) got8_d = 1'b1;
                    end else if (scl_fall && got8_q) begin
                        got8_d = 1'b0;
                        // General call (0x00) is never claimed.
                        if (shift_q[7:1] == TARGET_ADDR && shift_q[7:1] != '0) begin
                            sda_oe_d = 1'b1;
                            busy_d   = 1'b1;
                            state_d  = ADDR_ACK;
                        end else begin
                            state_d = IGNORE;
                        end
                    end
                end

                ADDR_ACK: begin
                    if (scl_fall) begin
                        bit_cnt_d = '0;
                        if (shift_q[0] == I2C_RW_READ) begin
                            tx_req_d = 1'b1;
                            state_d  = TX;
                        end else begin
                            sda_oe_d = 1'b0;
                            state_d  = RX;
                        end
                    end
                end

                RX: begin
                    if (scl_rise) begin
                        shift_d   = shifted;
                        bit_cnt_d = I2C_BIT_CNT_W'(bit_cnt_q + 1'b1);
                        if (bit_cnt_q == '1) begin
                            rx_data_d  = shifted;
                            rx_valid_d = 1'b1;
                            got8_d     = 1'b1;
                        end
                    end else if (scl_fall && got8_q) begin
                        got8_d   = 1'b0;
                        sda_oe_d = ~rx_full;
                        state_d  = RX_ACK;
                    end
                end

                RX_ACK: begin
                    if (scl_fall) begin
                        sda_oe_d  = 1'b0;
                        bit_cnt_d = '0;
                        state_d   = RX;
                    end
                end

                // bit_cnt counts falls after the MSB: 0..6 drive bits 6..0, 7 releases.
                TX: begin
                    if (scl_fall) begin
                        if (bit_cnt_q == '1) begin
                            sda_oe_d  = 1'b0;
                            bit_cnt_d = '0;
                            state_d   = TX_ACK;
                        end else begin
                            shift_d   = {shift_q[I2C_BYTE_W-2:0], 1'b0};
                            sda_oe_d  = ~shift_q[I2C_BYTE_W-2];
                            bit_cnt_d = I2C_BIT_CNT_W'(bit_cnt_q + 1'b1);
                        end
                    end
                end

                TX_ACK: begin
                    if (scl_rise) begin
                        nack_d = sda_lvl;
                    end else if (scl_fall) begin
                        if (nack_q == I2C_NACK) begin
                            sda_oe_d = 1'b0;
                            state_d  = IGNORE;
                        end else begin
                            tx_req_d  = 1'b1;
                            bit_cnt_d = '0;
                            state_d   = TX;
                        end
                    end
                end

                IGNORE: sda_oe_d = 1'b0;

                default: state_d = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_target.sv
// Self-checking bench for i2c_target: the bench plays the bus controller,
// expected write bytes go into a scoreboard queue and are matched against
// rx_valid strobes; read bytes are matched against the tx_data presented.
module tb_i2c_target;
    import i2c_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       scl;
    logic       sda_ctl;
    logic       sda_line;
    logic       sda_oe;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_full;
    logic [7:0] tx_data;
    logic       tx_req;
    logic       busy;

    int n_checks = 0;
    int n_errors = 0;
    int tx_req_cnt = 0;
    int oe_cnt = 0;

    logic [7:0] rx_exp_q[$];
    logic [7:0] rx_obs_q[$];
    logic [7:0] tx_exp_q[$];

    always #5 clk = ~clk;

    // Open-drain bus: either side can pull SDA low.
    assign sda_line = sda_ctl & ~sda_oe;

    i2c_target #(.TARGET_ADDR(7'h54), .SYNC_STAGES(2)) dut (
        .clk      (clk),
        .rst      (rst),
        .scl_i    (scl),
        .sda_i    (sda_line),
        .sda_oe   (sda_oe),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_full  (rx_full),
        .tx_data  (tx_data),
        .tx_req   (tx_req),
        .busy     (busy)
    );

    always @(negedge clk) begin
        if (rx_valid) rx_obs_q.push_back(rx_data);
        if (tx_req)   tx_req_cnt++;
        if (sda_oe)   oe_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic quarter();
        repeat (4) @(negedge clk);
    endtask

    task automatic i2c_start();
        sda_ctl = 1'b1; quarter();
        scl     = 1'b1; quarter();
        sda_ctl = 1'b0; quarter();
        scl     = 1'b0; quarter();
    endtask

    task automatic i2c_stop();
        sda_ctl = 1'b0; quarter();
        scl     = 1'b1; quarter();
        sda_ctl = 1'b1; quarter();
        quarter();
    endtask

    task automatic write_bit(input logic b);
        sda_ctl = b; quarter();
        scl = 1'b1;  quarter(); quarter();
        scl = 1'b0;  quarter();
    endtask

    task automatic read_bit(output logic b);
        sda_ctl = 1'b1; quarter();
        scl = 1'b1;     quarter();
        b = sda_line;   quarter();
        scl = 1'b0;     quarter();
    endtask

    task automatic write_byte(input logic [7:0] data, output logic ack);
        for (int i = 7; i >= 0; i--) write_bit(data[i]);
        read_bit(ack);
    endtask

    task automatic read_byte(output logic [7:0] data);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            read_bit(b);
            data[i] = b;
        end
    endtask

    // Pair observed and expected rx bytes in order, then flag leftovers.
    task automatic drain_rx(input string tag);
        while (rx_obs_q.size() > 0 && rx_exp_q.size() > 0)
            check(tag, 32'(rx_obs_q.pop_front()), 32'(rx_exp_q.pop_front()));
        check({tag, "_extra_rx"},   32'(rx_obs_q.size()), 32'd0);
        check({tag, "_missing_rx"}, 32'(rx_exp_q.size()), 32'd0);
        rx_obs_q.delete();
        rx_exp_q.delete();
    endtask

    task automatic check_tx_byte(input string tag, input logic [7:0] got);
        if (tx_exp_q.size() == 0) check({tag, "_no_exp"}, 32'd1, 32'd0);
        else check(tag, 32'(got), 32'(tx_exp_q.pop_front()));
    endtask

    initial begin
        logic       ack;
        logic       b;
        logic [7:0] rd;
        int         base;
        int         waited;

        rst = 1'b0; scl = 1'b1; sda_ctl = 1'b1; rx_full = 1'b0; tx_data = 8'h00;
        repeat (5) @(negedge clk);
        check("rst_sda_oe",   32'(sda_oe),   32'd0);
        check("rst_rx_data",  32'(rx_data),  32'd0);
        check("rst_rx_valid", 32'(rx_valid), 32'd0);
        check("rst_tx_req",   32'(tx_req),   32'd0);
        check("rst_busy",     32'(busy),     32'd0);
        check("rst_state",    32'(dut.state_q), 32'(IDLE));
        rst = 1'b1;
        repeat (5) @(negedge clk);

        // Write hit
        i2c_start();
        write_byte(8'hA8, ack);
        check("wr_addr_ack", 32'(ack), 32'(I2C_ACK));
        check("wr_busy", 32'(busy), 32'd1);
        rx_exp_q.push_back(8'h4D);
        write_byte(8'h4D, ack);
        check("wr_data_ack", 32'(ack), 32'(I2C_ACK));
        i2c_stop();
        drain_rx("wr_rx");
        check("wr_busy_after_stop", 32'(busy), 32'd0);

        // Address miss
        base = oe_cnt;
        i2c_start();
        write_byte(8'hAA, ack);
        check("miss_addr_nack", 32'(ack), 32'(I2C_NACK));
        write_byte(8'h12, ack);
        check("miss_data_nack", 32'(ack), 32'(I2C_NACK));
        check("miss_state", 32'(dut.state_q), 32'(IGNORE));
        check("miss_busy", 32'(busy), 32'd0);
        i2c_stop();
        check("miss_oe_cycles", 32'(oe_cnt - base), 32'd0);
        check("miss_state_stop", 32'(dut.state_q), 32'(IDLE));
        drain_rx("miss_rx");

        // Read two bytes, ACK then NACK
        base = tx_req_cnt;
        tx_data = 8'h96; tx_exp_q.push_back(8'h96);
        i2c_start();
        write_byte(8'hA9, ack);
        check("rd_addr_ack", 32'(ack), 32'(I2C_ACK));
        read_byte(rd);
        check_tx_byte("rd_byte0", rd);
        tx_data = 8'h3C; tx_exp_q.push_back(8'h3C);
        write_bit(I2C_ACK);
        read_byte(rd);
        check_tx_byte("rd_byte1", rd);
        write_bit(I2C_NACK);
        check("rd_released_after_nack", 32'(sda_oe), 32'd0);
        check("rd_state_after_nack", 32'(dut.state_q), 32'(IGNORE));
        i2c_stop();
        check("rd_tx_req_count", 32'(tx_req_cnt - base), 32'd2);
        check("rd_busy_after_stop", 32'(busy), 32'd0);
        drain_rx("rd_rx");

        // Backpressure on the second byte
        i2c_start();
        write_byte(8'hA8, ack);
        check("bp_addr_ack", 32'(ack), 32'(I2C_ACK));
        rx_exp_q.push_back(8'h11);
        write_byte(8'h11, ack);
        check("bp_byte1_ack", 32'(ack), 32'(I2C_ACK));
        rx_full = 1'b1;
        rx_exp_q.push_back(8'h22);
        write_byte(8'h22, ack);
        check("bp_byte2_nack", 32'(ack), 32'(I2C_NACK));
        rx_full = 1'b0;
        i2c_stop();
        drain_rx("bp_rx");

        // Repeated START: write then read
        base = tx_req_cnt;
        i2c_start();
        write_byte(8'hA8, ack);
        check("rs_wr_addr_ack", 32'(ack), 32'(I2C_ACK));
        rx_exp_q.push_back(8'h55);
        write_byte(8'h55, ack);
        check("rs_wr_data_ack", 32'(ack), 32'(I2C_ACK));
        i2c_start();
        check("rs_state_addr", 32'(dut.state_q), 32'(ADDR));
        check("rs_busy_cleared", 32'(busy), 32'd0);
        tx_data = 8'hC3; tx_exp_q.push_back(8'hC3);
        write_byte(8'hA9, ack);
        check("rs_rd_addr_ack", 32'(ack), 32'(I2C_ACK));
        check("rs_busy_read", 32'(busy), 32'd1);
        read_byte(rd);
        check_tx_byte("rs_rd_byte", rd);
        write_bit(I2C_NACK);
        i2c_stop();
        check("rs_tx_req_count", 32'(tx_req_cnt - base), 32'd1);
        check("rs_busy_after_stop", 32'(busy), 32'd0);
        drain_rx("rs_rx");

        // Reset while the target drives SDA in a read
        tx_data = 8'h96;
        i2c_start();
        write_byte(8'hA9, ack);
        check("rr_addr_ack", 32'(ack), 32'(I2C_ACK));
        read_bit(b);
        check("rr_bit7", 32'(b), 32'd1);
        waited = 0;
        while (!sda_oe && waited < 16) begin
            @(negedge clk);
            waited++;
        end
        check("rr_oe_before_rst", 32'(sda_oe), 32'd1);
        #2 rst = 1'b0;
        #1;
        check("rr_oe_in_rst",       32'(sda_oe),   32'd0);
        check("rr_busy_in_rst",     32'(busy),     32'd0);
        check("rr_rx_data_in_rst",  32'(rx_data),  32'd0);
        check("rr_rx_valid_in_rst", 32'(rx_valid), 32'd0);
        check("rr_tx_req_in_rst",   32'(tx_req),   32'd0);
        scl = 1'b1; sda_ctl = 1'b1;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        repeat (4) @(negedge clk);
        rx_obs_q.delete();
        i2c_start();
        write_byte(8'hA8, ack);
        check("rr_post_addr_ack", 32'(ack), 32'(I2C_ACK));
        rx_exp_q.push_back(8'h5A);
        write_byte(8'h5A, ack);
        check("rr_post_data_ack", 32'(ack), 32'(I2C_ACK));
        i2c_stop();
        check("rr_post_busy", 32'(busy), 32'd0);
        drain_rx("rr_rx");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
